// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, RAM handshake state and arbiter FSM types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: instruction/data request ports and the shared RAM port of the arbiter
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // requesters and RAM model side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between I and D requesters; define ARB_ROUNDROBIN_EN for alternating priority, else fixed D priority with starvation limit
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input logic             CLK,
    input logic             RST,
    memory_arbiter_if.slave bus
);

    arb_state_t state_q, state_d, cur;
    logic       d_req, pick_i, done;

    assign d_req = bus.dREN | bus.dWEN;

`ifdef ARB_ROUNDROBIN_EN
    logic last_i_q, last_i_d;

    // the requester granted last loses the next contention
    always_comb begin
        pick_i   = bus.iREN && (!d_req || !last_i_q);
        last_i_d = last_i_q;
        if (state_q == IDLE && state_d != IDLE) last_i_d = (state_d == GRANT_I);
    end

    // pointer register; reset makes D the preferred requester
    always_ff @(posedge CLK) begin
        if (RST) last_i_q <= 1'b1;
        else     last_i_q <= last_i_d;
    end
`else
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          starved;

    // D wins unless I has waited through STARVE_MAX consecutive D grants
    always_comb begin
        starved  = (starve_q == CW'(STARVE_MAX));
        pick_i   = bus.iREN && (!d_req || starved);
        starve_d = starve_q;
        if (state_q == IDLE)
            starve_d = pick_i ? '0 :
                       (d_req && bus.iREN) ? (starved ? starve_q : starve_q + 1'b1) :
                       !bus.iREN ? '0 : starve_q;
    end

    // starvation counter register
    always_ff @(posedge CLK) begin
        if (RST) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state and RAM/requester muxing; reset forces the idle outputs
    always_comb begin
        cur          = RST ? IDLE : state_q;
        state_d      = cur;
        done         = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.iwait    = bus.iREN;
        bus.dwait    = d_req;
        case (cur)
            IDLE: state_d = pick_i ? GRANT_I : d_req ? GRANT_D : IDLE;
            GRANT_I: begin
                done        = bus.iREN && bus.ramstate == ACCESS;
                bus.ramREN  = bus.iREN;
                bus.ramaddr = bus.iREN ? bus.iaddr : '0;
                bus.iwait   = bus.iREN && !done;
                bus.iload   = done ? bus.ramload : '0;
                state_d     = (!bus.iREN || done) ? IDLE : GRANT_I;
            end
            GRANT_D: begin
                done         = d_req && bus.ramstate == ACCESS;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN && !bus.dWEN;
                bus.ramaddr  = d_req ? bus.daddr : '0;
                bus.ramstore = bus.dWEN ? bus.dstore : '0;
                bus.dwait    = d_req && !done;
                bus.dload    = done ? bus.ramload : '0;
                state_d      = (!d_req || done) ? IDLE : GRANT_D;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
